window_spill_fill: RTL
======================

WINDOW_SPILL_FILL -- requirements
Module: window_spill_fill

Interface
REQ-001 Parameter DATA_W, default 16, register and memory data width.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-006 dir  input  1  0 = spill (regfile to memory), 1 = fill (memory to regfile); sampled with start.
REQ-007 win  input  2  register window to transfer; sampled with start.
REQ-008 base_addr  input  ADDR_W  memory address of window slot 0; sampled with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a transfer completes.
REQ-011 rf_window, rf_ri, rf_rj  output  2 each  register-file window and port selects.
REQ-012 rf_reg_write  output  1  register-file write enable, to write port Ri.
REQ-013 rf_write_data  output  DATA_W  register-file write data.
REQ-014 rf_read_data1, rf_read_data2  input  DATA_W  combinational register-file read data for Ri and Rj.
REQ-015 mem_req, mem_we  output  1 each  memory request and write-not-read.
REQ-016 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W.
REQ-017 mem_ack  input  1; mem_rdata  input  DATA_W, valid in the cycle mem_ack is high.

Function
REQ-018 States: IDLE, SPILL_RD, SPILL_WR, FILL_RD, FILL_WR, CLEAR (macro only), DONE.
REQ-019 IDLE: start=1 latches dir, win and base_addr, clears slot index idx to 0, and enters SPILL_RD (dir=0) or FILL_RD (dir=1).
REQ-020 start while busy is ignored; latched win, base_addr and dir do not change mid-transfer.
REQ-021 SPILL_RD, one cycle: rf_window=win, rf_ri=idx, rf_rj=idx+1; rf_read_data1/2 captured into buf0/buf1; next SPILL_WR.
REQ-022 SPILL_WR: issues two memory writes, buf0 to base_addr+idx, then buf1 to base_addr+idx+1; each write holds mem_req=1, mem_we=1 and stable addr/data until mem_ack=1 is sampled.
REQ-023 After the second ack, idx += 2; idx 2 returns to SPILL_RD; idx wrapping to 0 goes to DONE, or to CLEAR with the macro.
REQ-024 FILL_RD: mem_req=1, mem_we=0, mem_addr=base_addr+idx, held until mem_ack=1; mem_rdata is captured on the ack cycle; next FILL_WR.
REQ-025 FILL_WR, one cycle: rf_reg_write=1, rf_window=win, rf_ri=idx, rf_write_data=captured word; idx==3 goes to DONE, otherwise idx += 1 and back to FILL_RD.
REQ-026 DONE, one cycle: done=1, busy=1; next IDLE.
REQ-027 mem_ack sampled while mem_req=0 is ignored; same-cycle ack (zero wait) is legal.
REQ-028 Address arithmetic is modulo 2^ADDR_W (base_addr+idx wraps); idx is 2 bits and wraps.
REQ-029 Latency with mem_ack tied high: spill done is cycle 7 after start is sampled; fill done is cycle 9; stalls add cycles one-for-one.
REQ-030 rf_reg_write=1 only in FILL_WR and CLEAR; mem_req=1 only in SPILL_WR and FILL_RD.

Reset
REQ-031 rst=0 at an edge forces IDLE, idx=0, busy=0, done=0, rf_reg_write=0, mem_req=0, mem_we=0, and all address, data and select outputs to 0.
REQ-032 Reset mid-transfer abandons the transfer without completing pending memory or regfile writes; done does not pulse.

Configuration
REQ-033 Macro SPILL_FILL_CLEAR_EN defined: after a spill, CLEAR writes 0 to window slots 0..3 over 4 cycles (rf_reg_write=1, rf_ri=idx), then DONE; spill done moves to cycle 11.
REQ-034 Macro undefined: the CLEAR state and logic do not exist; spill goes straight to DONE; fill is unaffected.

Structure
REQ-035 A shared package holds the state enum, DATA_W/ADDR_W defaults, WIN_W=2 and REGS_PER_WIN=4.
REQ-036 Single module, no sub-module; the FSM, idx counter and the two data buffers are local.

Verification
REQ-037 Regfile window 0 = {1,2,3,4}, start spill win=0 base=0x0100, ack tied high -> writes 1,2,3,4 to 0x0100..0x0103, done at cycle 7.
REQ-038 Memory 0x0200..0x0203 = {9,8,7,6}, fill win=2, ack delayed 3 cycles -> win2 slots = 9,8,7,6, each write a single-cycle rf_reg_write, done only after the last write.
REQ-039 start pulsed again during a spill -> ignored, exactly 4 memory writes, one done pulse.
REQ-040 rst=0 during the second FILL_RD -> next cycle busy=0, mem_req=0, slots 2..3 unchanged, no done.
REQ-041 base_addr=0xFFFE spill -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-042 With SPILL_FILL_CLEAR_EN, spill win=1 holding {5,5,5,5} -> memory gets 5s, slots read 0 after done at cycle 11.

Source files
------------

// File: rtl/window_spill_fill_pkg.sv
// Shared constants for the register-window spill/fill engine: widths, window geometry, FSM codes.
// Purely declarative; no logic, so no latency or backpressure of its own.
// Holds constants only; users include it with `import window_spill_fill_pkg::*;`.
package window_spill_fill_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 16;
    localparam int WIN_W        = 2;
    localparam int REGS_PER_WIN = 4;

    // FSM encodings; ST_CLEAR is only reachable when SPILL_FILL_CLEAR_EN is defined
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SPILL_RD = 3'd1;
    localparam logic [2:0] ST_SPILL_WR = 3'd2;
    localparam logic [2:0] ST_FILL_RD  = 3'd3;
    localparam logic [2:0] ST_FILL_WR  = 3'd4;
    localparam logic [2:0] ST_CLEAR    = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

endpackage

// File: rtl/window_spill_fill.sv
// Moves one 4-register window between the register file and memory (spill or fill).
// Latency with zero-wait memory: spill done at cycle 7 (11 with SPILL_FILL_CLEAR_EN), fill at cycle 9.
// Backpressure: each memory access holds mem_req/addr/data until mem_ack; stalls add cycles one-for-one.
module window_spill_fill
    import window_spill_fill_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [WIN_W-1:0]  win,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [WIN_W-1:0]  rf_window,
    output logic [WIN_W-1:0]  rf_ri,
    output logic [WIN_W-1:0]  rf_rj,
    output logic              rf_reg_write,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q,   idx_d;
    logic              half_q,  half_d;
    logic [WIN_W-1:0]  win_q,   win_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [DATA_W-1:0] buf0_q,  buf0_d;
    logic [DATA_W-1:0] buf1_q,  buf1_d;

    logic [1:0] idx_p2;
    logic       last_slot;

    assign idx_p2    = idx_q + 2'd2;
    assign last_slot = (idx_q == 2'(REGS_PER_WIN - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        half_d  = half_q;
        win_d   = win_q;
        base_d  = base_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_d   = win;
                    base_d  = base_addr;
                    idx_d   = 2'd0;
                    half_d  = 1'b0;
                    state_d = dir ? ST_FILL_RD : ST_SPILL_RD;
                end
            end
            ST_SPILL_RD: begin
                buf0_d  = rf_read_data1;
                buf1_d  = rf_read_data2;
                half_d  = 1'b0;
                state_d = ST_SPILL_WR;
            end
            ST_SPILL_WR: begin
                // half_q selects the second word of the pair
                if (mem_ack) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        idx_d  = idx_p2;
                        if (idx_p2 != 2'd0) begin
                            state_d = ST_SPILL_RD;
                        end else begin
`ifdef SPILL_FILL_CLEAR_EN
                            state_d = ST_CLEAR;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
            ST_FILL_RD: begin
                if (mem_ack) begin
                    buf0_d  = mem_rdata;
                    state_d = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_FILL_RD;
                end
            end
`ifdef SPILL_FILL_CLEAR_EN
            ST_CLEAR: begin
                if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        rf_window     = '0;
        rf_ri         = '0;
        rf_rj         = '0;
        rf_reg_write  = 1'b0;
        rf_write_data = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state_q)
            ST_SPILL_RD: begin
                rf_window = win_q;
                rf_ri     = idx_q;
                rf_rj     = idx_q + 2'd1;
            end
            ST_SPILL_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(idx_q) + ADDR_W'(half_q);
                mem_wdata = half_q ? buf1_q : buf0_q;
            end
            ST_FILL_RD: begin
                mem_req  = 1'b1;
                mem_addr = base_q + ADDR_W'(idx_q);
            end
            ST_FILL_WR: begin
                rf_reg_write  = 1'b1;
                rf_window     = win_q;
                rf_ri         = idx_q;
                rf_write_data = buf0_q;
            end
`ifdef SPILL_FILL_CLEAR_EN
            ST_CLEAR: begin
                rf_reg_write = 1'b1;
                rf_window    = win_q;
                rf_ri        = idx_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            half_q  <= 1'b0;
            win_q   <= '0;
            base_q  <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            win_q   <= win_d;
            base_q  <= base_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

endmodule
